// File: rtl/mod_mult_arb.sv
// rtl/mod_mult_arb.sv - round-robin arbiter sharing one pipelined modular multiplier
module mod_mult_arb #(
    parameter int                   NB_REQ     = 4,
    parameter int                   MOD_NTT_W  = 64,
    parameter logic [MOD_NTT_W-1:0] MOD_NTT    = 64'hFFFF_FFFF_0000_0001,
    parameter int                   MULT_LAT   = 5,
    parameter int                   INFL_DEPTH = MULT_LAT + 2
) (
    input  logic                          clk,
    input  logic                          s_rst_n,
    input  logic [NB_REQ-1:0]             req_vld,
    input  logic [NB_REQ*MOD_NTT_W-1:0]   req_a,
    input  logic [NB_REQ*MOD_NTT_W-1:0]   req_b,
    output logic [NB_REQ-1:0]             req_rdy,
    output logic [MOD_NTT_W-1:0]          mult_a,
    output logic [MOD_NTT_W-1:0]          mult_b,
    output logic                          mult_avail,
    input  logic [MOD_NTT_W-1:0]          mult_z,
    input  logic                          mult_z_avail,
    output logic [MOD_NTT_W-1:0]          rsp_z,
    output logic [NB_REQ-1:0]             rsp_avail,
    output logic [1:0]                    error,
    output logic                          busy
);

    localparam int ID_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int PTR_W = (INFL_DEPTH > 1) ? $clog2(INFL_DEPTH) : 1;
    localparam int CNT_W = $clog2(INFL_DEPTH + 1);

    logic                  rst_done_q, rst_done_d;
    logic [ID_W-1:0]       prio_ptr_q, prio_ptr_d;
    logic [MOD_NTT_W-1:0]  mult_a_q, mult_a_d;
    logic [MOD_NTT_W-1:0]  mult_b_q, mult_b_d;
    logic                  mult_avail_q, mult_avail_d;
    logic [MOD_NTT_W-1:0]  rsp_z_q, rsp_z_d;
    logic [NB_REQ-1:0]     rsp_avail_q, rsp_avail_d;
    logic [1:0]            error_q, error_d;
    logic [ID_W-1:0]       id_mem_q [INFL_DEPTH];
    logic [ID_W-1:0]       id_mem_d [INFL_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    int                    scan_idx;
    logic [ID_W-1:0]       scan_id;
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [MOD_NTT_W-1:0]  grant_a, grant_b;
    logic                  fifo_full, pop, push;

    assign pop       = mult_z_avail && (cnt_q != '0);
    assign fifo_full = (cnt_q == CNT_W'(INFL_DEPTH));
    assign push      = grant_vld;
    assign grant_a   = req_a[grant_id*MOD_NTT_W +: MOD_NTT_W];
    assign grant_b   = req_b[grant_id*MOD_NTT_W +: MOD_NTT_W];

    // Round-robin scan from prio_ptr; a pop in the same cycle frees a slot in a full FIFO
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        scan_id   = '0;
        req_rdy   = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            scan_idx = int'(prio_ptr_q) + i;
            if (scan_idx >= NB_REQ) begin
                scan_idx = scan_idx - NB_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!grant_vld && req_vld[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
        if (!rst_done_q || (fifo_full && !pop)) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    // Issue path, response path, sticky errors and in-flight ID FIFO next state
    always_comb begin
        rst_done_d   = 1'b1;
        mult_avail_d = push;
        mult_a_d     = push ? grant_a : mult_a_q;
        mult_b_d     = push ? grant_b : mult_b_q;
        prio_ptr_d   = prio_ptr_q;
        if (push) begin
            prio_ptr_d = (grant_id == ID_W'(NB_REQ - 1)) ? '0 : grant_id + 1'b1;
        end

        error_d = error_q;
        if (push && ((grant_a >= MOD_NTT) || (grant_b >= MOD_NTT))) begin
            error_d[0] = 1'b1;
        end
        if (mult_z_avail && (cnt_q == '0)) begin
            error_d[1] = 1'b1;
        end

        rsp_avail_d = '0;
        rsp_z_d     = rsp_z_q;
        if (pop) begin
            rsp_z_d                         = mult_z;
            rsp_avail_d[id_mem_q[rd_ptr_q]] = 1'b1;
        end

        id_mem_d = id_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            id_mem_d[wr_ptr_q] = grant_id;
            wr_ptr_d = (wr_ptr_q == PTR_W'(INFL_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(INFL_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards every in-flight ID
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rst_done_q   <= 1'b0;
            prio_ptr_q   <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_avail_q <= 1'b0;
            rsp_z_q      <= '0;
            rsp_avail_q  <= '0;
            error_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < INFL_DEPTH; i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            rst_done_q   <= rst_done_d;
            prio_ptr_q   <= prio_ptr_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_avail_q <= mult_avail_d;
            rsp_z_q      <= rsp_z_d;
            rsp_avail_q  <= rsp_avail_d;
            error_q      <= error_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            id_mem_q     <= id_mem_d;
        end
    end

    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_avail = mult_avail_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_avail  = rsp_avail_q;
    assign error      = error_q;
    assign busy       = mult_avail_q | (cnt_q != '0);

endmodule

// File: tb/tb_mod_mult_arb.sv
// tb/tb_mod_mult_arb.sv - directed self-checking bench for mod_mult_arb
module tb_mod_mult_arb;

    localparam int          NB = 4;
    localparam int          W  = 64;
    localparam int          L  = 5;
    localparam int          D  = 7;
    localparam logic [63:0] P  = 64'hFFFF_FFFF_0000_0001;

    logic              clk;
    logic              s_rst_n;
    logic [NB-1:0]     req_vld;
    logic [NB*W-1:0]   req_a;
    logic [NB*W-1:0]   req_b;
    logic [NB-1:0]     req_rdy;
    logic [W-1:0]      mult_a;
    logic [W-1:0]      mult_b;
    logic              mult_avail;
    logic [W-1:0]      mult_z;
    logic              mult_z_avail;
    logic [W-1:0]      rsp_z;
    logic [NB-1:0]     rsp_avail;
    logic [1:0]        error;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    // multiplier model: fixed latency L, optional hold, plus spurious injection
    typedef struct {
        int          due;
        logic [63:0] z;
    } ent_t;
    ent_t        mq[$];
    int          ecnt      = 0;
    logic        hold      = 1'b0;
    logic        model_zav = 1'b0;
    logic [63:0] model_z   = '0;
    logic        spur_zav  = 1'b0;
    logic [63:0] spur_z    = '0;

    typedef struct {
        logic [3:0]  av;
        logic [63:0] z;
        int          cyc;
    } rsp_t;
    rsp_t rsp_log[$];

    assign mult_z_avail = model_zav | spur_zav;
    assign mult_z       = spur_zav ? spur_z : model_z;

    mod_mult_arb #(
        .NB_REQ(NB), .MOD_NTT_W(W), .MOD_NTT(P), .MULT_LAT(L), .INFL_DEPTH(D)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_avail(mult_avail),
        .mult_z(mult_z), .mult_z_avail(mult_z_avail),
        .rsp_z(rsp_z), .rsp_avail(rsp_avail), .error(error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, P});
    endfunction

    always @(posedge clk) begin
        if (mult_avail) mq.push_back('{due: ecnt + L - 1, z: mulmod(mult_a, mult_b)});
        if (!hold && mq.size() > 0 && mq[0].due <= ecnt) begin
            model_zav <= 1'b1;
            model_z   <= mq[0].z;
            mq.pop_front();
        end else begin
            model_zav <= 1'b0;
        end
        ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (rsp_avail != '0) rsp_log.push_back('{av: rsp_avail, z: rsp_z, cyc: tcyc});
    end

    task automatic wait_rsp(input int n);
        for (int c = 0; c < 40 && rsp_log.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (rsp_log.size() != n) begin
            failures++;
            $display("FAIL rsp_count got=%0d exp=%0d", rsp_log.size(), n);
        end
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; req_vld = '1; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", req_rdy); end
        checks++;
        if ({mult_avail, rsp_avail, error, busy} !== 8'd0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {mult_avail, rsp_avail, error, busy});
        end
        checks++;
        if (mult_a !== 64'd0 || mult_b !== 64'd0 || rsp_z !== 64'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", mult_a, mult_b, rsp_z);
        end
        @(negedge clk);
        s_rst_n = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin failures++; $display("FAIL release_rdy got=%b exp=0000", req_rdy); end
        @(negedge clk);
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", req_rdy); end
        req_vld = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy;
        logic [63:0] exp_z[8];
        int          acc0 = 0;
        rsp_log.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_vld = '1;
            for (int i = 0; i < NB; i++) begin
                req_a[i*W +: W] = 64'(k*16 + i + 1);
                req_b[i*W +: W] = 64'd7;
            end
            #1;
            if (k > 0) begin
                checks++;
                if (mult_avail !== 1'b1) begin failures++; $display("FAIL rr_mult_avail cyc%0d got=%b exp=1", k, mult_avail); end
            end
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (req_rdy !== exp_rdy) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
            if (k == 0) acc0 = tcyc;
            exp_z[k] = 64'((k*16 + (k % 4) + 1) * 7);
        end
        @(negedge clk);
        req_vld = '0;
        #1;
        checks++;
        if (mult_avail !== 1'b1) begin failures++; $display("FAIL rr_mult_avail_last got=%b exp=1", mult_avail); end
        wait_rsp(8);
        for (int j = 0; j < rsp_log.size() && j < 8; j++) begin
            exp_rdy = 4'b0001 << (j % 4);
            checks++;
            if (rsp_log[j].av !== exp_rdy || rsp_log[j].z !== exp_z[j]) begin
                failures++;
                $display("FAIL rr_rsp j=%0d got=%b/%0d exp=%b/%0d", j, rsp_log[j].av, rsp_log[j].z, exp_rdy, exp_z[j]);
            end
        end
        if (rsp_log.size() > 0) begin
            checks++;
            if (rsp_log[0].cyc - acc0 != L + 2) begin
                failures++; $display("FAIL rr_latency got=%0d exp=%0d", rsp_log[0].cyc - acc0, L + 2);
            end
        end
    endtask

    task automatic test_single();
        int acc;
        rsp_log.delete();
        @(negedge clk);
        req_vld = 4'b0100;
        req_a[2*W +: W] = 64'd3;
        req_b[2*W +: W] = 64'd5;
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_rdy); end
        acc = tcyc;
        @(negedge clk);
        req_vld = '0;
        #1;
        checks++;
        if (mult_avail !== 1'b1 || mult_a !== 64'd3 || mult_b !== 64'd5) begin
            failures++; $display("FAIL single_issue got=%b/%0d/%0d exp=1/3/5", mult_avail, mult_a, mult_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mult_avail !== 1'b0 || mult_a !== 64'd3) begin
            failures++; $display("FAIL single_idle got=%b/%0d exp=0/3", mult_avail, mult_a);
        end
        wait_rsp(1);
        if (rsp_log.size() > 0) begin
            checks++;
            if (rsp_log[0].av !== 4'b0100 || rsp_log[0].z !== 64'd15 || rsp_log[0].cyc - acc != L + 2) begin
                failures++;
                $display("FAIL single_rsp got=%b/%0d/lat%0d exp=0100/15/lat%0d", rsp_log[0].av, rsp_log[0].z, rsp_log[0].cyc - acc, L + 2);
            end
        end
    endtask

    task automatic test_operand_check();
        rsp_log.delete();
        @(negedge clk);
        req_vld = 4'b0010;
        req_a[1*W +: W] = P;
        req_b[1*W +: W] = 64'd1;
        #1;
        checks++;
        if (req_rdy !== 4'b0010 || error !== 2'b00) begin
            failures++; $display("FAIL opchk_grant got=%b/%b exp=0010/00", req_rdy, error);
        end
        @(negedge clk);
        req_vld = '0;
        #1;
        checks++;
        if (error !== 2'b01 || mult_a !== P) begin failures++; $display("FAIL opchk_error got=%b/%h exp=01/%h", error, mult_a, P); end
        wait_rsp(1);
        if (rsp_log.size() > 0) begin
            checks++;
            if (rsp_log[0].av !== 4'b0010 || rsp_log[0].z !== 64'd0) begin
                failures++; $display("FAIL opchk_rsp got=%b/%0d exp=0010/0", rsp_log[0].av, rsp_log[0].z);
            end
        end
    endtask

    task automatic test_spurious();
        rsp_log.delete();
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle got=%b exp=0", busy); end
        spur_z   = 64'd99;
        spur_zav = 1'b1;
        @(negedge clk);
        spur_zav = 1'b0;
        #1;
        checks++;
        if (error !== 2'b11 || rsp_avail !== 4'b0000) begin
            failures++; $display("FAIL spur_error got=%b/%b exp=11/0000", error, rsp_avail);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_log.size() != 0) begin failures++; $display("FAIL spur_rsp got=%0d exp=0", rsp_log.size()); end
    endtask

    task automatic test_full_guard();
        int   grants = 0;
        logic seen   = 1'b0;
        rsp_log.delete();
        hold = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_vld = 4'b0001;
            req_a[0 +: W] = 64'(1000 + grants);
            req_b[0 +: W] = 64'd3;
            #1;
            if (req_rdy == 4'b0001) grants++;
        end
        checks++;
        if (grants != D || req_rdy !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL full_stall got=%0d/%b/%b exp=%0d/0000/1", grants, req_rdy, busy, D);
        end
        hold = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (mult_z_avail) begin
                seen = 1'b1;
                if (req_rdy !== 4'b0001) begin failures++; $display("FAIL full_pop_grant got=%b exp=0001", req_rdy); end
                else grants++;
            end else if (req_rdy !== 4'b0000) begin
                failures++; $display("FAIL full_wait_rdy got=%b exp=0000", req_rdy);
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL full_pop_timeout got=0 exp=1"); end
        @(negedge clk);
        req_vld = '0;
        wait_rsp(8);
        for (int j = 0; j < rsp_log.size() && j < 8; j++) begin
            checks++;
            if (rsp_log[j].av !== 4'b0001 || rsp_log[j].z !== 64'((1000 + j) * 3)) begin
                failures++;
                $display("FAIL full_rsp j=%0d got=%b/%0d exp=0001/%0d", j, rsp_log[j].av, rsp_log[j].z, (1000 + j) * 3);
            end
        end
        checks++;
        if (error !== 2'b11) begin failures++; $display("FAIL sticky_error got=%b exp=11", error); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_rdy;
        rsp_log.delete();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_vld = '1;
            #1;
            exp_rdy = 4'b0001 << ((k + 1) % 4);
            checks++;
            if (req_rdy !== exp_rdy) begin failures++; $display("FAIL mid_grant k=%0d got=%b exp=%b", k, req_rdy, exp_rdy); end
        end
        @(negedge clk);
        req_vld = '0;
        @(negedge clk);
        s_rst_n = 1'b0;
        req_vld = '1;
        #1;
        checks++;
        if ({req_rdy, mult_avail, rsp_avail, error, busy} !== 12'd0) begin
            failures++; $display("FAIL mid_reset_ctrl got=%b exp=0", {req_rdy, mult_avail, rsp_avail, error, busy});
        end
        checks++;
        if (mult_a !== 64'd0 || mult_b !== 64'd0 || rsp_z !== 64'd0) begin
            failures++; $display("FAIL mid_reset_data got=%h/%h/%h exp=0", mult_a, mult_b, rsp_z);
        end
        @(negedge clk);
        req_vld = '0;
        s_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (error !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL mid_post_release got=%b/%b exp=00/0", error, busy); end
        hold = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (rsp_log.size() != 0 || error !== 2'b10) begin
            failures++; $display("FAIL mid_late_products got=%0d/%b exp=0/10", rsp_log.size(), error);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_operand_check();
        test_spurious();
        test_full_guard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_mult_arb.md
MOD_MULT_ARB -- requirements
Module: mod_mult_arb

Interface
REQ-001 SHALL have parameter NB_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter MOD_NTT_W, default 64, operand/modulus width.
REQ-003 SHALL have parameter MOD_NTT, default 2**64-2**32+1, Goldilocks prime used for the operand range check.
REQ-004 SHALL have parameter MULT_LAT, default 5, nominal latency of the shared external pipelined modular multiplier.
REQ-005 SHALL have parameter INFL_DEPTH, default MULT_LAT+2, depth of the in-flight ID FIFO.
REQ-006 SHALL have one clock and reset: clk in 1 (rising edge); s_rst_n in 1 (asynchronous, active-low).
REQ-007 req_vld  in  NB_REQ  per-requester operand valid.
REQ-008 req_a  in  NB_REQ*MOD_NTT_W  operand A, requester i at slice i.
REQ-009 req_b  in  NB_REQ*MOD_NTT_W  operand B, same packing.
REQ-010 req_rdy  out  NB_REQ  one-hot-or-zero grant; handshake = req_vld[i] & req_rdy[i].
REQ-011 mult_a, mult_b  out  MOD_NTT_W each  operands to the multiplier (registered).
REQ-012 mult_avail  out  1  operand strobe to the multiplier (registered).
REQ-013 mult_z  in  MOD_NTT_W  product from the multiplier.
REQ-014 mult_z_avail  in  1  product strobe from the multiplier.
REQ-015 rsp_z  out  MOD_NTT_W  product, broadcast to all requesters (registered).
REQ-016 rsp_avail  out  NB_REQ  one-hot result strobe to the owning requester (registered).
REQ-017 error  out  2  sticky flags: [0] operand >= MOD_NTT; [1] product with no in-flight entry.
REQ-018 busy  out  1  high while mult_avail=1 or the in-flight FIFO is non-empty.

Function
REQ-019 Arbitration SHALL be round-robin: scan starts at prio_ptr, wraps at NB_REQ-1 to 0; the first i with req_vld[i]=1 gets req_rdy[i]=1.
REQ-020 req_rdy SHALL be combinational from req_vld, prio_ptr and FIFO status; at most one bit set per cycle.
REQ-021 On handshake by requester g, prio_ptr SHALL become (g+1) mod NB_REQ; with no handshake it SHALL hold.
REQ-022 req_rdy SHALL be all-zero when the in-flight FIFO holds INFL_DEPTH entries and no pop occurs that cycle; with a pop in the same cycle, grant SHALL proceed.
REQ-023 On handshake at cycle T: mult_a/mult_b SHALL carry the granted operands and mult_avail=1 at T+1; the ID g SHALL be pushed into the FIFO at T+1.
REQ-024 Without a handshake, mult_avail SHALL be 0 the next cycle; mult_a/mult_b hold their last value.
REQ-025 Throughput SHALL be one issue per cycle sustained, with no bubbles on requester switch.
REQ-026 On mult_z_avail at cycle U with a non-empty FIFO: pop head ID h; rsp_z=mult_z and rsp_avail=one-hot(h) at U+1.
REQ-027 Simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-028 Results SHALL return in issue order (FIFO order); total latency accept-to-rsp = MULT_LAT+2 cycles.
REQ-029 mult_z_avail with an empty FIFO SHALL set error[1], drop the product and keep rsp_avail=0.
REQ-030 A handshake with a granted operand >= MOD_NTT SHALL set error[0]; the operation SHALL still be issued unmodified.
REQ-031 Error bits SHALL be sticky and clear only on reset.
REQ-032 No backpressure on responses: requesters SHALL accept rsp_avail in the cycle it is asserted.

Reset
REQ-033 While s_rst_n=0: mult_avail=0, rsp_avail=0, error=0, busy=0, req_rdy=0, prio_ptr=0, FIFO empty, mult_a/mult_b/rsp_z=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight IDs; products arriving after release with an empty FIFO SHALL set error[1].
REQ-035 The first grant after reset release SHALL be one cycle after s_rst_n rises, starting the scan from requester 0.

Verification
REQ-036 Single request: req 2 sends a=3, b=5; multiplier model returns 15 -> rsp_avail=4'b0100, rsp_z=15, MULT_LAT+2 cycles after accept.
REQ-037 All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; mult_avail high all 8 cycles; results returned in the same order.
REQ-038 Operand check: req 1 sends a=2**64-2**32+1, b=1 -> error=2'b01 one cycle after accept; product still returned to req 1.
REQ-039 Spurious product: mult_z_avail=1 with an idle FIFO -> error[1]=1; rsp_avail stays 0.
REQ-040 Full guard: the multiplier model delays products until INFL_DEPTH=7 are outstanding -> req_rdy=0 until the first pop, then a grant occurs in that pop cycle.
REQ-041 Reset after 3 issues with results pending -> outputs at REQ-033 values; the 3 late products set error[1] with no rsp_avail.
